// File: rtl/vga_sync_sr_gen_if.sv
// Timing-generator bus: pixel tick in, counters, active flag and sync set/reset pulses out.
// The generator owns the master side; the colour path and sync SR flops sit on the slave side.
interface vga_sync_sr_gen_if #(
    parameter int CW = 10
) ();
    logic          en;
    logic [CW-1:0] h_cnt;
    logic [CW-1:0] v_cnt;
    logic          active;
    logic          hs_set;
    logic          hs_rst;
    logic          vs_set;
    logic          vs_rst;
    logic          frame_start;

    modport master (
        input  en,
        output h_cnt, v_cnt, active, hs_set, hs_rst, vs_set, vs_rst, frame_start
    );

    modport slave (
        output en,
        input  h_cnt, v_cnt, active, hs_set, hs_rst, vs_set, vs_rst, frame_start
    );
endinterface

// File: rtl/vga_sync_sr_gen.sv
// Pixel/line counters driving S/R pulses for the HSYNC/VSYNC flops; pulses are registered and align
// with the cycle the counters show their new value. No backpressure: en simply gates advancement.
module vga_sync_sr_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CW       = 10
) (
    input logic               clk,
    input logic               rst,
    vga_sync_sr_gen_if.master bus
);
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    // A sync end that lands exactly on the period boundary fires on the wrap to 0.
    localparam int HS_END_W = (HS_END == H_TOTAL) ? 0 : HS_END;
    localparam int VS_END_W = (VS_END == V_TOTAL) ? 0 : VS_END;

    localparam logic [CW-1:0] H_LAST_C   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST_C   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] HS_START_C = CW'(HS_START);
    localparam logic [CW-1:0] HS_END_C   = CW'(HS_END_W);
    localparam logic [CW-1:0] VS_START_C = CW'(VS_START);
    localparam logic [CW-1:0] VS_END_C   = CW'(VS_END_W);
    localparam logic [CW-1:0] H_ACTIVE_C = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACTIVE_C = CW'(V_ACTIVE);

    logic [CW-1:0] h_q;
    logic [CW-1:0] v_q;
    logic [CW-1:0] h_nxt;
    logic [CW-1:0] v_nxt;
    logic          h_wrap;
    logic          v_wrap;
    logic          hs_set_q;
    logic          hs_rst_q;
    logic          vs_set_q;
    logic          vs_rst_q;
    logic          frame_start_q;

    always_comb begin
        h_wrap = (h_q == H_LAST_C);
        v_wrap = (v_q == V_LAST_C);
        h_nxt  = h_wrap ? '0 : h_q + CW'(1);
        v_nxt  = v_q;
        if (h_wrap) begin
            v_nxt = v_wrap ? '0 : v_q + CW'(1);
        end
    end

    // Pulses decode the value being loaded, so they land with the counter update.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_q           <= '0;
            v_q           <= '0;
            hs_set_q      <= 1'b0;
            hs_rst_q      <= 1'b0;
            vs_set_q      <= 1'b0;
            vs_rst_q      <= 1'b0;
            frame_start_q <= 1'b0;
        end else if (bus.en) begin
            h_q           <= h_nxt;
            v_q           <= v_nxt;
            hs_set_q      <= (h_nxt == HS_START_C);
            hs_rst_q      <= (h_nxt == HS_END_C);
            vs_set_q      <= h_wrap && (v_nxt == VS_START_C);
            vs_rst_q      <= h_wrap && (v_nxt == VS_END_C);
            frame_start_q <= h_wrap && v_wrap;
        end else begin
            hs_set_q      <= 1'b0;
            hs_rst_q      <= 1'b0;
            vs_set_q      <= 1'b0;
            vs_rst_q      <= 1'b0;
            frame_start_q <= 1'b0;
        end
    end

    assign bus.h_cnt       = h_q;
    assign bus.v_cnt       = v_q;
    assign bus.active      = (h_q < H_ACTIVE_C) && (v_q < V_ACTIVE_C);
    assign bus.hs_set      = hs_set_q;
    assign bus.hs_rst      = hs_rst_q;
    assign bus.vs_set      = vs_set_q;
    assign bus.vs_rst      = vs_rst_q;
    assign bus.frame_start = frame_start_q;
endmodule

// File: tb/tb_vga_sync_sr_gen.sv
// Bench for vga_sync_sr_gen: a full-size VGA instance and a tiny-timing instance, each shadowed
// by a linear pixel-index model; plus a vector table and corner-case sequences.
module tb_vga_sync_sr_gen;
    localparam int A_HT = 800, A_VT = 525, A_HA = 640, A_VA = 480;
    localparam int A_HSS = 656, A_HSE = 752, A_VSS = 490, A_VSE = 492;
    localparam int B_HT = 8, B_VT = 6, B_HA = 4, B_VA = 3;
    localparam int B_HSS = 5, B_HSE = 7, B_VSS = 4, B_VSE = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a;
    logic rst_b;

    vga_sync_sr_gen_if #(.CW(10)) bus_a ();
    vga_sync_sr_gen_if #(.CW(4))  bus_b ();

    vga_sync_sr_gen #(
        .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
        .V_ACTIVE(480), .V_FP(10), .V_SYNC(2),  .V_BP(33), .CW(10)
    ) dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (bus_a.master)
    );

    vga_sync_sr_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .CW(4)
    ) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (bus_b.master)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: linear pixel index within the frame plus the pulses it implies.
    int         na = 0;
    int         nb = 0;
    logic [4:0] pa = '0;
    logic [4:0] pb = '0;

    typedef struct {
        bit         rst;
        bit         en;
        int         h;
        int         v;
        logic [4:0] p;
        bit         act;
    } vec_t;

    vec_t tbl[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Pulse order {hs_set, hs_rst, vs_set, vs_rst, frame_start} for a freshly reached index n.
    function automatic logic [4:0] pulses_of(input int n, input int ht, input int vt,
                                             input int hss, input int hse,
                                             input int vss, input int vse);
        int h;
        int v;
        h = n % ht;
        v = n / ht;
        return {h == hss, h == (hse % ht), (h == 0) && (v == vss),
                (h == 0) && (v == (vse % vt)), n == 0};
    endfunction

    task automatic cyc_a(input bit r, input bit e);
        logic [31:0] act;
        logic [31:0] exp;
        rst_a    = r;
        bus_a.en = e;
        @(posedge clk);
        if (r) begin
            na = 0;
            pa = '0;
        end else if (e) begin
            na = (na + 1) % (A_HT * A_VT);
            pa = pulses_of(na, A_HT, A_VT, A_HSS, A_HSE, A_VSS, A_VSE);
        end else begin
            pa = '0;
        end
        @(negedge clk);
        act = {6'b0, bus_a.h_cnt, bus_a.v_cnt, bus_a.active, bus_a.hs_set, bus_a.hs_rst,
               bus_a.vs_set, bus_a.vs_rst, bus_a.frame_start};
        exp = {6'b0, 10'(na % A_HT), 10'(na / A_HT),
               ((na % A_HT) < A_HA) && ((na / A_HT) < A_VA), pa};
        check("a_model", act, exp);
    endtask

    task automatic cyc_b(input bit r, input bit e);
        logic [31:0] act;
        logic [31:0] exp;
        rst_b    = r;
        bus_b.en = e;
        @(posedge clk);
        if (r) begin
            nb = 0;
            pb = '0;
        end else if (e) begin
            nb = (nb + 1) % (B_HT * B_VT);
            pb = pulses_of(nb, B_HT, B_VT, B_HSS, B_HSE, B_VSS, B_VSE);
        end else begin
            pb = '0;
        end
        @(negedge clk);
        act = {18'b0, bus_b.h_cnt, bus_b.v_cnt, bus_b.active, bus_b.hs_set, bus_b.hs_rst,
               bus_b.vs_set, bus_b.vs_rst, bus_b.frame_start};
        exp = {18'b0, 4'(nb % B_HT), 4'(nb / B_HT),
               ((nb % B_HT) < B_HA) && ((nb / B_HT) < B_VA), pb};
        check("b_model", act, exp);
    endtask

    function automatic logic [31:0] b_pulses();
        return {27'b0, bus_b.hs_set, bus_b.hs_rst, bus_b.vs_set, bus_b.vs_rst, bus_b.frame_start};
    endfunction

    initial begin
        int ec;
        int found;
        int c_hss, c_hsr, c_vss, c_vsr, c_fs, c_v3, c_v3act, last_fs, c_fs_after;

        rst_a    = 1'b1;
        rst_b    = 1'b1;
        bus_a.en = 1'b0;
        bus_b.en = 1'b0;

        tbl[0]  = '{1, 1, 0, 0, 5'b00000, 1};
        tbl[1]  = '{1, 0, 0, 0, 5'b00000, 1};
        tbl[2]  = '{0, 1, 1, 0, 5'b00000, 1};
        tbl[3]  = '{0, 1, 2, 0, 5'b00000, 1};
        tbl[4]  = '{0, 0, 2, 0, 5'b00000, 1};
        tbl[5]  = '{0, 1, 3, 0, 5'b00000, 1};
        tbl[6]  = '{0, 1, 4, 0, 5'b00000, 0};
        tbl[7]  = '{0, 1, 5, 0, 5'b10000, 0};
        tbl[8]  = '{0, 0, 5, 0, 5'b00000, 0};
        tbl[9]  = '{0, 1, 6, 0, 5'b00000, 0};
        tbl[10] = '{0, 1, 7, 0, 5'b01000, 0};
        tbl[11] = '{0, 1, 0, 1, 5'b00000, 1};

        @(negedge clk);

        // Full-size timing: two reset cycles then continuous pixel ticks over two lines.
        cyc_a(1, 1);
        cyc_a(1, 1);
        check("a_reset_h", 32'(bus_a.h_cnt), 0);
        check("a_reset_active", 32'(bus_a.active), 1);
        for (int k = 1; k <= 1600; k++) begin
            cyc_a(0, 1);
            if (k == 639) check("a_active_639", 32'(bus_a.active), 1);
            if (k == 640) check("a_active_640", 32'(bus_a.active), 0);
            if (k == 655) check("a_hs_set_655", 32'(bus_a.hs_set), 0);
            if (k == 656) check("a_hs_set_656", 32'(bus_a.hs_set), 1);
            if (k == 657) check("a_hs_set_657", 32'(bus_a.hs_set), 0);
            if (k == 752) check("a_hs_rst_752", 32'(bus_a.hs_rst), 1);
            if (k == 800) check("a_wrap_hv", {bus_a.h_cnt, bus_a.v_cnt}, {10'd0, 10'd1});
        end

        // Pixel tick one clock in four.
        cyc_a(1, 0);
        ec = 0;
        for (int k = 0; k < 2800; k++) begin
            cyc_a(0, (k % 4) == 0);
            if ((k % 4) == 0) ec++;
            if (ec == 656) begin
                if ((k % 4) == 0) check("a_q_hs_set", 32'(bus_a.hs_set), 1);
                else check("a_q_hold", {bus_a.hs_set, bus_a.h_cnt}, {1'b0, 10'd656});
            end
        end

        // Random ticks with rare resets.
        for (int k = 0; k < 20000; k++) begin
            cyc_a($urandom_range(0, 1999) == 0, $urandom_range(0, 3) != 0);
        end

        // Small timing: vector table from reset.
        foreach (tbl[i]) begin
            cyc_b(tbl[i].rst, tbl[i].en);
            check("b_tbl_h", 32'(bus_b.h_cnt), tbl[i].h);
            check("b_tbl_v", 32'(bus_b.v_cnt), tbl[i].v);
            check("b_tbl_pulses", b_pulses(), 32'(tbl[i].p));
            check("b_tbl_active", 32'(bus_b.active), 32'(tbl[i].act));
        end

        // Three whole frames with continuous ticks.
        c_hss = 0; c_hsr = 0; c_vss = 0; c_vsr = 0; c_fs = 0; c_v3 = 0; c_v3act = 0;
        last_fs = -1;
        for (int k = 0; k < 144; k++) begin
            cyc_b(0, 1);
            c_hss += int'(bus_b.hs_set);
            c_hsr += int'(bus_b.hs_rst);
            c_vss += int'(bus_b.vs_set);
            c_vsr += int'(bus_b.vs_rst);
            if (bus_b.v_cnt == 4'd3) begin
                c_v3++;
                c_v3act += int'(bus_b.active);
            end
            if (bus_b.vs_set) check("b_vs_set_pos", {bus_b.h_cnt, bus_b.v_cnt}, {4'd0, 4'd4});
            if (bus_b.vs_rst) check("b_vs_rst_pos", {bus_b.h_cnt, bus_b.v_cnt}, {4'd0, 4'd5});
            if (bus_b.frame_start) begin
                c_fs++;
                check("b_fs_pos", {bus_b.h_cnt, bus_b.v_cnt}, 0);
                if (last_fs >= 0) check("b_fs_period", k - last_fs, 48);
                last_fs = k;
            end
        end
        check("b_cnt_hs_set", c_hss, 18);
        check("b_cnt_hs_rst", c_hsr, 18);
        check("b_cnt_vs_set", c_vss, 3);
        check("b_cnt_vs_rst", c_vsr, 3);
        check("b_cnt_frame_start", c_fs, 3);
        check("b_v3_cycles", c_v3, 24);
        check("b_v3_active", c_v3act, 0);

        // Reset in the middle of a line.
        found = 0;
        for (int i = 0; i < 100 && found == 0; i++) begin
            if (bus_b.h_cnt == 4'd6 && bus_b.v_cnt == 4'd2) found = 1;
            else cyc_b(0, 1);
        end
        check("b_find_h6v2", found, 1);
        cyc_b(1, 1);
        check("b_midrst_hv", {bus_b.h_cnt, bus_b.v_cnt}, 0);
        check("b_midrst_pulses", b_pulses(), 0);
        check("b_midrst_active", 32'(bus_b.active), 1);
        c_fs_after = 0;
        for (int i = 1; i <= 5; i++) begin
            cyc_b(0, 1);
            c_fs_after += int'(bus_b.frame_start);
            if (i == 5) check("b_midrst_hs_set", {bus_b.hs_set, bus_b.h_cnt}, {1'b1, 4'd5});
        end
        check("b_midrst_no_fs", c_fs_after, 0);

        // Random ticks with occasional resets.
        for (int k = 0; k < 3000; k++) begin
            cyc_b($urandom_range(0, 199) == 0, $urandom_range(0, 1) == 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
